// File: rtl/img_decoding.sv
`default_nettype none
// ============================================================================
// Module      : img_decoding
// Description : Run-length image decoder. Expands 16-bit code words
//               ({run_length-1, pixel}) into a raster stream of 8-bit
//               pixels with a frame-relative address. Flags runs that
//               cross a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module img_decoding #(
    parameter int PIC_SIZE = 4096,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [7:0]        pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_done,
    output logic              overrun_err
);

    localparam logic [0:0]        c_ST_LOAD   = 1'b0;
    localparam logic [0:0]        c_ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [8:0]        r_remain;
    logic [7:0]        r_pix;
    logic [ADDR_W-1:0] r_addr;
    logic              r_frame_done;
    logic              r_overrun_err;

    logic              w_last_addr;
    logic              w_run_last;
    logic              w_pix_hs;
    logic              w_code_acc;

    // Frame-end and run-end conditions of the pixel currently presented.
    assign w_last_addr = (r_addr == c_LAST_ADDR);
    assign w_run_last  = (r_remain == 9'd1);

    // A new code is only taken mid-stream when it can replace the last pixel
    // of a run without a bubble; the frame's last pixel always returns to LOAD.
    assign code_ready = (r_state == c_ST_LOAD) ? 1'b1
                      : (w_run_last && pix_ready && !w_last_addr);

    assign w_pix_hs   = (r_state == c_ST_RUN) && pix_ready;
    assign w_code_acc = code_valid && code_ready;

    assign pix_valid   = (r_state == c_ST_RUN);
    assign pix_out     = r_pix;
    assign pix_addr    = r_addr;
    assign frame_done  = r_frame_done;
    assign overrun_err = r_overrun_err;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave RUN when the run or the frame is exhausted,
    // unless a chained code is loaded on the run's last pixel.
    always_comb begin
        w_state_next = r_state;
        if (r_state == c_ST_LOAD) begin
            if (w_code_acc) begin
                w_state_next = c_ST_RUN;
            end
        end else begin
            if (w_pix_hs) begin
                if (w_last_addr) begin
                    w_state_next = c_ST_LOAD;
                end else if (w_run_last && !w_code_acc) begin
                    w_state_next = c_ST_LOAD;
                end
            end
        end
    end

    // Run datapath: load a code, or count down one pixel per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix    <= 8'd0;
            r_remain <= 9'd0;
        end else begin
            if (w_code_acc) begin
                r_pix    <= code_in[7:0];
                r_remain <= {1'b0, code_in[15:8]} + 9'd1;
            end else if (w_pix_hs) begin
                // At frame end any leftover pixels of the run are discarded.
                r_remain <= w_last_addr ? 9'd0 : (r_remain - 9'd1);
            end
        end
    end

    // Raster address, frame-end pulse and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_frame_done  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pix_hs) begin
                if (w_last_addr) begin
                    r_addr       <= '0;
                    r_frame_done <= 1'b1;
                    if (r_remain > 9'd1) begin
                        r_overrun_err <= 1'b1;
                    end
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_img_decoding.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_decoding
// Description : Directed self-checking bench for img_decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_decoding;

    localparam int PIC_SIZE = 4096;
    localparam int ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       code_in = 16'h0000;
    logic              code_valid = 1'b0;
    logic              code_ready;
    logic [7:0]        pix_out;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic [ADDR_W-1:0] pix_addr;
    logic              frame_done;
    logic              overrun_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    img_decoding #(
        .PIC_SIZE(PIC_SIZE),
        .ADDR_W  (ADDR_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_addr   (pix_addr),
        .frame_done (frame_done),
        .overrun_err(overrun_err)
    );

    // Reset the DUT and return at a falling edge with idle inputs.
    task automatic apply_reset();
        rst        = 1'b1;
        code_valid = 1'b0;
        code_in    = 16'h0000;
        pix_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        code_valid = 1'b0;
        pix_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid: got %b expected 0", pix_valid); end
        n_tests++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL rst_pix_out: got %h expected 00", pix_out); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL idle_code_ready: got %b expected 1", code_ready); end
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL idle_pix_valid: got %b expected 0", pix_valid); end
        n_tests++; if (pix_addr !== 16'd0) begin n_fail++; $display("FAIL idle_pix_addr: got %0d expected 0", pix_addr); end
        n_tests++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL idle_overrun: got %b expected 0", overrun_err); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        code_in = 16'h3542;   // 54 pixels
        code_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        repeat (4) @(negedge clk);   // 4 handshakes, 50 pixels left
        #1;
        n_tests++; if (pix_addr !== 16'd4) begin n_fail++; $display("FAIL midrun_addr: got %0d expected 4", pix_addr); end
        rst = 1'b1;
        #1;
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pix_valid: got %b expected 0", pix_valid); end
        n_tests++; if (pix_addr !== 16'd0) begin n_fail++; $display("FAIL arst_pix_addr: got %0d expected 0", pix_addr); end
        n_tests++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL arst_pix_out: got %h expected 00", pix_out); end
        n_tests++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL arst_code_ready: got %b expected 1", code_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        code_in = 16'h0341;
        code_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code_in = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 1", k, pix_valid); end
            n_tests++; if (pix_out !== 8'h41) begin n_fail++; $display("FAIL single_pix[%0d]: got %h expected 41", k, pix_out); end
            n_tests++; if (pix_addr !== 16'(k)) begin n_fail++; $display("FAIL single_addr[%0d]: got %0d expected %0d", k, pix_addr, k); end
            n_tests++; if (code_ready !== (k == 3)) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected %b", k, code_ready, (k == 3)); end
            @(negedge clk);
        end
        #1;
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b expected 0", pix_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] codes [0:2];
        logic [7:0]  exp_pix [0:3];
        logic        exp_rdy [0:3];
        int          idx;
        logic        acc;
        codes   = '{16'h0010, 16'h0120, 16'h0030};
        exp_pix = '{8'h10, 8'h20, 8'h20, 8'h30};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        idx = 0;
        code_in = codes[0];
        code_valid = 1'b1;
        pix_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            acc = code_valid && code_ready;
            if (c >= 1 && c <= 4) begin
                n_tests++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c, pix_valid); end
                n_tests++; if (pix_out !== exp_pix[c-1]) begin n_fail++; $display("FAIL b2b_pix[%0d]: got %h expected %h", c, pix_out, exp_pix[c-1]); end
                n_tests++; if (pix_addr !== 16'(c-1)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", c, pix_addr, c-1); end
                n_tests++; if (code_ready !== exp_rdy[c-1]) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, code_ready, exp_rdy[c-1]); end
            end else if (c == 5) begin
                n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b expected 0", pix_valid); end
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) code_in = codes[idx];
                else code_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic        rdy_pat [0:4];
        logic [15:0] exp_addr [0:4];
        int          hs;
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
        apply_reset();
        code_in = 16'h0277;
        code_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            pix_ready = rdy_pat[c];
            #1;
            n_tests++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, pix_valid); end
            n_tests++; if (pix_out !== 8'h77) begin n_fail++; $display("FAIL bp_pix[%0d]: got %h expected 77", c, pix_out); end
            n_tests++; if (pix_addr !== exp_addr[c]) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d expected %0d", c, pix_addr, exp_addr[c]); end
            if (pix_valid && pix_ready) hs++;
            @(negedge clk);
        end
        pix_ready = 1'b1;
        #1;
        n_tests++; if (hs != 3) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected 3", hs); end
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b expected 0", pix_valid); end
    endtask

    task automatic test_full_frame();
        logic [15:0] codes [0:16];
        int          idx;
        int          p;
        int          fd_seen;
        logic        acc;
        logic [7:0]  exp_pix;
        for (int k = 0; k < 16; k++) codes[k] = {8'hFF, 8'(k + 1)};
        codes[16] = 16'h0055;
        apply_reset();
        idx = 0;
        fd_seen = 0;
        code_in = codes[0];
        code_valid = 1'b1;
        pix_ready = 1'b1;
        for (int c = 0; c < 4100; c++) begin
            #1;
            acc = code_valid && code_ready;
            if (c >= 1 && c <= PIC_SIZE) begin
                p = c - 1;
                exp_pix = 8'(p / 256 + 1);
                n_tests++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL ff_valid[%0d]: got %b expected 1", p, pix_valid); end
                n_tests++; if (pix_out !== exp_pix) begin n_fail++; $display("FAIL ff_pix[%0d]: got %h expected %h", p, pix_out, exp_pix); end
                n_tests++; if (pix_addr !== 16'(p)) begin n_fail++; $display("FAIL ff_addr[%0d]: got %0d expected %0d", p, pix_addr, p); end
                if (frame_done) fd_seen++;
                if (p == 255) begin
                    n_tests++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL ff_ready_run_end: got %b expected 1", code_ready); end
                end
                if (p == PIC_SIZE - 1) begin
                    n_tests++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ready_frame_end: got %b expected 0", code_ready); end
                end
            end else if (c == PIC_SIZE + 1) begin
                n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL ff_frame_done: got %b expected 1", frame_done); end
                n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL ff_bubble_valid: got %b expected 0", pix_valid); end
                n_tests++; if (pix_addr !== 16'd0) begin n_fail++; $display("FAIL ff_wrap_addr: got %0d expected 0", pix_addr); end
                n_tests++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL ff_overrun: got %b expected 0", overrun_err); end
                n_tests++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL ff_bubble_ready: got %b expected 1", code_ready); end
            end else if (c == PIC_SIZE + 2) begin
                n_tests++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL ff_next_valid: got %b expected 1", pix_valid); end
                n_tests++; if (pix_out !== 8'h55) begin n_fail++; $display("FAIL ff_next_pix: got %h expected 55", pix_out); end
                n_tests++; if (pix_addr !== 16'd0) begin n_fail++; $display("FAIL ff_next_addr: got %0d expected 0", pix_addr); end
                n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL ff_done_width: got %b expected 0", frame_done); end
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 17) code_in = codes[idx];
                else code_valid = 1'b0;
            end
        end
        n_tests++; if (fd_seen != 0) begin n_fail++; $display("FAIL ff_early_done: got %0d expected 0", fd_seen); end
        n_tests++; if (idx != 17) begin n_fail++; $display("FAIL ff_codes_taken: got %0d expected 17", idx); end
    endtask

    task automatic test_overrun();
        logic [15:0] codes [0:17];
        int          idx;
        int          p;
        logic        acc;
        logic [7:0]  exp_pix;
        for (int k = 0; k < 15; k++) codes[k] = {8'hFF, 8'(k + 1)};
        codes[15] = 16'hF910;   // 250 pixels -> 4090 total
        codes[16] = 16'h09AA;   // 10 pixels, only 6 fit
        codes[17] = 16'h0011;
        apply_reset();
        idx = 0;
        code_in = codes[0];
        code_valid = 1'b1;
        pix_ready = 1'b1;
        for (int c = 0; c < 4100; c++) begin
            #1;
            acc = code_valid && code_ready;
            if (c >= 1 && c <= PIC_SIZE) begin
                p = c - 1;
                if (p < 3840) exp_pix = 8'(p / 256 + 1);
                else if (p < 4090) exp_pix = 8'h10;
                else exp_pix = 8'hAA;
                n_tests++; if (pix_out !== exp_pix) begin n_fail++; $display("FAIL ov_pix[%0d]: got %h expected %h", p, pix_out, exp_pix); end
                n_tests++; if (pix_addr !== 16'(p)) begin n_fail++; $display("FAIL ov_addr[%0d]: got %0d expected %0d", p, pix_addr, p); end
                if (p == PIC_SIZE - 1) begin
                    n_tests++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL ov_early_err: got %b expected 0", overrun_err); end
                    n_tests++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL ov_ready_last: got %b expected 0", code_ready); end
                end
            end else if (c == PIC_SIZE + 1) begin
                n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL ov_frame_done: got %b expected 1", frame_done); end
                n_tests++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ov_err_set: got %b expected 1", overrun_err); end
                n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL ov_discard_valid: got %b expected 0", pix_valid); end
                n_tests++; if (pix_addr !== 16'd0) begin n_fail++; $display("FAIL ov_wrap_addr: got %0d expected 0", pix_addr); end
            end else if (c == PIC_SIZE + 2) begin
                n_tests++; if (pix_out !== 8'h11) begin n_fail++; $display("FAIL ov_next_pix: got %h expected 11", pix_out); end
                n_tests++; if (pix_addr !== 16'd0) begin n_fail++; $display("FAIL ov_next_addr: got %0d expected 0", pix_addr); end
                n_tests++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ov_err_sticky: got %b expected 1", overrun_err); end
            end else if (c == PIC_SIZE + 3) begin
                n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL ov_next_end: got %b expected 0", pix_valid); end
                n_tests++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ov_err_hold: got %b expected 1", overrun_err); end
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 18) code_in = codes[idx];
                else code_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_full_frame();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
